// File: rtl/ir_loader_pkg.sv
// ir_loader_pkg
// Shared definitions for the IR preload engine: default word/address widths,
// the timeout counter width and the loader state encoding.
package ir_loader_pkg;

  // Default instruction word width and IR file address width.
  localparam int IRR_WIDTH_DEF     = 16;
  localparam int IR_ADDR_WIDTH_DEF = 4;

  // The timeout counter must hold TIMEOUT-1 for TIMEOUT up to 65535.
  localparam int TCNT_WIDTH = 16;

  // Loader states; codes are fixed so they can be matched in waveforms.
  typedef enum logic [2:0] {
    LINIT     = 3'd0,
    LREAD_MEM = 3'd1,
    LWRITE    = 3'd2,
    LWORK     = 3'd3,
    LERR      = 3'd4
  } ld_state_e;

endpackage

// File: rtl/ir_loader.sv
// ir_loader
// Instruction-register preload engine. After a start pulse it reads
// 2**IR_ADDR_WIDTH consecutive words from program memory (req/ack port) and
// writes each one into ir_regfile through its data_in/address/mode port.
// When every line is loaded, init_finished releases ir_regfile.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_start        single-cycle load command (ignored while busy)
//   i_base_addr    memory address of IR line 0, sampled on accepted start
//   o_mem_req      read request to program memory
//   o_mem_addr     read address, stable while o_mem_req=1
//   i_mem_ack      read acknowledge, i_mem_rdata valid in the same cycle
//   i_mem_rdata    read data
//   o_ir_data      write data to ir_regfile
//   o_ir_address   write line to ir_regfile
//   o_ir_mode      write enable to ir_regfile, one cycle per word
//   o_init_finished all lines loaded (sticky until the next start)
//   o_busy         load in progress
//   o_err          load aborted on timeout (sticky until the next start)
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int IRR_WIDTH      = IRR_WIDTH_DEF,
  parameter int IR_ADDR_WIDTH  = IR_ADDR_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [MEM_ADDR_WIDTH-1:0] i_base_addr,
  output logic                      o_mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [IRR_WIDTH-1:0]      i_mem_rdata,
  output logic [IRR_WIDTH-1:0]      o_ir_data,
  output logic [IR_ADDR_WIDTH-1:0]  o_ir_address,
  output logic                      o_ir_mode,
  output logic                      o_init_finished,
  output logic                      o_busy,
  output logic                      o_err
);

  // Last permitted wait cycle: an ack seen while the counter holds this value
  // is still honoured, so err rises exactly TIMEOUT cycles after the request.
  localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TIMEOUT - 1);

  ld_state_e                 r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_base;
  logic [IR_ADDR_WIDTH-1:0]  r_count;
  logic [TCNT_WIDTH-1:0]     r_tcnt;
  logic                      r_mem_req;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [IRR_WIDTH-1:0]      r_ir_data;
  logic [IR_ADDR_WIDTH-1:0]  r_ir_address;
  logic                      r_ir_mode;
  logic                      r_init_finished;
  logic                      r_busy;
  logic                      r_err;

  logic [IR_ADDR_WIDTH-1:0]  w_next_count;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_last_line;

  assign w_next_count = r_count + IR_ADDR_WIDTH'(1'b1);
  // Addresses wrap modulo 2**MEM_ADDR_WIDTH by plain truncation.
  assign w_next_addr  = r_base + MEM_ADDR_WIDTH'(w_next_count);
  assign w_last_line  = (r_count == {IR_ADDR_WIDTH{1'b1}});

  // Loader FSM with line counter, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= LINIT;
      r_base          <= {MEM_ADDR_WIDTH{1'b0}};
      r_count         <= {IR_ADDR_WIDTH{1'b0}};
      r_tcnt          <= {TCNT_WIDTH{1'b0}};
      r_mem_req       <= 1'b0;
      r_mem_addr      <= {MEM_ADDR_WIDTH{1'b0}};
      r_ir_data       <= {IRR_WIDTH{1'b0}};
      r_ir_address    <= {IR_ADDR_WIDTH{1'b0}};
      r_ir_mode       <= 1'b0;
      r_init_finished <= 1'b0;
      r_busy          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      // ir_mode is a one-cycle pulse; only the ack path raises it.
      r_ir_mode <= 1'b0;
      case (r_state)
        LINIT, LWORK, LERR: begin
          if (i_start) begin
            r_state         <= LREAD_MEM;
            r_base          <= i_base_addr;
            r_count         <= {IR_ADDR_WIDTH{1'b0}};
            r_tcnt          <= {TCNT_WIDTH{1'b0}};
            r_mem_req       <= 1'b1;
            r_mem_addr      <= i_base_addr;
            r_init_finished <= 1'b0;
            r_busy          <= 1'b1;
            r_err           <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        LREAD_MEM: begin
          if (i_mem_ack) begin
            r_state      <= LWRITE;
            r_tcnt       <= {TCNT_WIDTH{1'b0}};
            r_mem_req    <= 1'b0;
            r_ir_data    <= i_mem_rdata;
            r_ir_address <= r_count;
            r_ir_mode    <= 1'b1;
          end else if (r_tcnt == TCNT_LAST) begin
            r_state   <= LERR;
            r_tcnt    <= {TCNT_WIDTH{1'b0}};
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TCNT_WIDTH'(1'b1);
          end
        end
        LWRITE: begin
          if (w_last_line) begin
            r_state         <= LWORK;
            r_busy          <= 1'b0;
            r_init_finished <= 1'b1;
          end else begin
            r_state    <= LREAD_MEM;
            r_count    <= w_next_count;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_next_addr;
          end
        end
        default: begin
          r_state   <= LINIT;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req       = r_mem_req;
  assign o_mem_addr      = r_mem_addr;
  assign o_ir_data       = r_ir_data;
  assign o_ir_address    = r_ir_address;
  assign o_ir_mode       = r_ir_mode;
  assign o_init_finished = r_init_finished;
  assign o_busy          = r_busy;
  assign o_err           = r_err;

endmodule
